// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with credit-limited requests and redirect flush
module fetch_ctrl #(
   parameter int              XLEN  = 32,
   parameter logic [XLEN-1:0] RESET = '0,
   parameter int              DEPTH = 2
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   input  logic            if_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW:0]   CREDIT  = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

   state_t          state;
   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] buf_pc    [DEPTH];
   logic [XLEN-1:0] buf_instr [DEPTH];
   logic [XLEN-1:0] iss_addr  [DEPTH];
   logic [AW-1:0]   buf_rd, buf_wr, iss_rd, iss_wr;
   logic [CW-1:0]   buf_cnt, out_cnt, drop_cnt;

   logic            grant, resp, drop, pop, redir;
   logic [CW:0]     credit_sum;
   logic [CW:0]     drop_next;

   // Credit counts both buffered and in-flight words so a response always has a slot.
   assign credit_sum = {1'b0, buf_cnt} + {1'b0, out_cnt};
   assign imem_req   = (state == RUN) && (credit_sum < CREDIT);
   assign imem_addr  = fpc;
   assign grant      = imem_req && imem_gnt;
   assign resp       = imem_rvalid && (drop_cnt == '0);
   assign drop       = imem_rvalid && (drop_cnt != '0);
   assign redir      = redirect && (state != BOOT);
   assign if_valid   = (buf_cnt != '0);
   assign if_pc      = buf_pc[buf_rd];
   assign if_instr   = buf_instr[buf_rd];
   assign pop        = if_valid && if_ready && !redir;

   // Everything granted so far (including this cycle) minus this cycle's answer stays unanswered.
   assign drop_next  = {1'b0, drop_cnt} + {1'b0, out_cnt} + {{CW{1'b0}}, grant}
                       - {{CW{1'b0}}, imem_rvalid};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= BOOT;
         fpc      <= RESET;
         buf_rd   <= '0;
         buf_wr   <= '0;
         iss_rd   <= '0;
         iss_wr   <= '0;
         buf_cnt  <= '0;
         out_cnt  <= '0;
         drop_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_pc[i]    <= '0;
            buf_instr[i] <= '0;
            iss_addr[i]  <= '0;
         end
      end else if (state == BOOT) begin
         state <= RUN;
      end else if (redir) begin
         fpc      <= {redirect_pc[XLEN-1:1], 1'b0};
         buf_rd   <= '0;
         buf_wr   <= '0;
         iss_rd   <= '0;
         iss_wr   <= '0;
         buf_cnt  <= '0;
         out_cnt  <= '0;
         drop_cnt <= drop_next[CW-1:0];
         state    <= (drop_next != '0) ? FLUSH : RUN;
      end else begin
         if (grant) begin
            fpc              <= fpc + XLEN'(4);
            iss_addr[iss_wr] <= fpc;
            iss_wr           <= iss_wr + PTR_ONE;
         end
         if (resp) begin
            buf_pc[buf_wr]    <= iss_addr[iss_rd];
            buf_instr[buf_wr] <= imem_rdata;
            buf_wr            <= buf_wr + PTR_ONE;
            iss_rd            <= iss_rd + PTR_ONE;
         end
         if (pop)
            buf_rd <= buf_rd + PTR_ONE;

         case ({grant, resp})
            2'b10:   out_cnt <= out_cnt + CNT_ONE;
            2'b01:   out_cnt <= out_cnt - CNT_ONE;
            default: out_cnt <= out_cnt;
         endcase
         case ({resp, pop})
            2'b10:   buf_cnt <= buf_cnt + CNT_ONE;
            2'b01:   buf_cnt <= buf_cnt - CNT_ONE;
            default: buf_cnt <= buf_cnt;
         endcase

         if (drop) begin
            drop_cnt <= drop_cnt - CNT_ONE;
            if (drop_cnt == CNT_ONE)
               state <= RUN;
         end
      end
   end

   assert property (@(posedge clock) disable iff (!reset_n)
                    !(resp && !redir && (buf_cnt == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed bench for fetch_ctrl with a latency-programmable memory model
module tb_fetch_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;

   int          n_cmp = 0;
   int          n_err = 0;

   logic [31:0] mq_addr [$];
   int          mq_due  [$];
   int          cyc = 0;
   int          lat = 1;
   int          gnt_cnt = 0;

   logic [31:0] got_pc  [$];
   logic [31:0] got_ins [$];

   fetch_ctrl dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .if_ready    (if_ready)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Memory: always grants, answers in order lat cycles later with data ~addr.
   always @(posedge clock) begin
      #1;
      if (!reset_n) begin
         mq_addr.delete();
         mq_due.delete();
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end else begin
         cyc++;
         imem_rvalid = 1'b0;
         if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~mq_addr[0];
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end
         imem_gnt = 1'b1;
         if (imem_req && imem_gnt) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + lat);
            gnt_cnt++;
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n && if_valid && if_ready && !redirect) begin
         got_pc.push_back(if_pc);
         got_ins.push_back(if_instr);
      end
   end

   task automatic restart(input int l, input logic rdy);
      reset_n = 1'b0;
      tick();
      tick();
      lat      = l;
      if_ready = rdy;
      gnt_cnt  = 0;
      got_pc.delete();
      got_ins.delete();
      reset_n  = 1'b1;
   endtask

   initial begin
      reset_n     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      if_ready    = 1'b1;
      repeat (3) tick();
      check("rst_req",    {31'b0, imem_req}, 32'd0);
      check("rst_addr",   imem_addr, 32'd0);
      check("rst_valid",  {31'b0, if_valid}, 32'd0);
      check("rst_pc",     if_pc, 32'd0);
      check("rst_instr",  if_instr, 32'd0);

      // Streaming from reset with a 1-cycle memory
      restart(1, 1'b1);
      check("boot_req", {31'b0, imem_req}, 32'd0);
      tick();
      check("c1_req",  {31'b0, imem_req}, 32'd1);
      check("c1_addr", imem_addr, 32'd0);
      tick();
      check("c2_addr",  imem_addr, 32'd4);
      check("c2_valid", {31'b0, if_valid}, 32'd0);
      tick();
      check("c3_valid", {31'b0, if_valid}, 32'd1);
      check("c3_pc",    if_pc, 32'd0);
      check("c3_instr", if_instr, 32'hffff_ffff);
      repeat (19) tick();
      check("stream_count", {31'b0, got_pc.size() >= 4}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("stream_pc%0d", i),  got_pc[i],  32'(4 * i));
         check($sformatf("stream_ins%0d", i), got_ins[i], ~32'(4 * i));
      end

      // Asynchronous reset mid-burst
      check("pre_rst_req",   {31'b0, imem_req}, 32'd1);
      check("pre_rst_valid", {31'b0, if_valid}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_req",   {31'b0, imem_req}, 32'd0);
      check("async_valid", {31'b0, if_valid}, 32'd0);
      check("async_addr",  imem_addr, 32'd0);

      // Backpressure: decode stalled, credits exhausted
      restart(1, 1'b0);
      tick();
      check("bp_c1_req",  {31'b0, imem_req}, 32'd1);
      check("bp_c1_addr", imem_addr, 32'd0);
      repeat (9) tick();
      check("bp_grants", 32'(gnt_cnt), 32'd2);
      check("bp_req",    {31'b0, imem_req}, 32'd0);
      check("bp_valid",  {31'b0, if_valid}, 32'd1);
      check("bp_pc",     if_pc, 32'd0);
      check("bp_instr",  if_instr, 32'hffff_ffff);
      if_ready = 1'b1;
      repeat (10) tick();
      check("bp_pc0", got_pc[0], 32'd0);
      check("bp_pc1", got_pc[1], 32'd4);
      check("bp_pc2", got_pc[2], 32'd8);

      // Redirect with nothing outstanding goes straight back to RUN
      if_ready = 1'b0;
      repeat (6) tick();
      check("rz_pre_req",   {31'b0, imem_req}, 32'd0);
      check("rz_pre_valid", {31'b0, if_valid}, 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      check("rz_req",   {31'b0, imem_req}, 32'd1);
      check("rz_addr",  imem_addr, 32'h40);
      check("rz_valid", {31'b0, if_valid}, 32'd0);

      // Redirect with two requests in flight, 3-cycle memory
      restart(3, 1'b1);
      tick();
      tick();
      tick();
      check("fl_c3_req", {31'b0, imem_req}, 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check("fl_c4_req", {31'b0, imem_req}, 32'd0);
      tick();
      check("fl_c5_req",   {31'b0, imem_req}, 32'd0);
      check("fl_c5_valid", {31'b0, if_valid}, 32'd0);
      tick();
      check("fl_c6_req",   {31'b0, imem_req}, 32'd1);
      check("fl_c6_addr",  imem_addr, 32'h100);
      check("fl_c6_valid", {31'b0, if_valid}, 32'd0);
      repeat (8) tick();
      check("fl_first_pc",  got_pc[0], 32'h100);
      check("fl_first_ins", got_ins[0], ~32'h100);

      // Redirect colliding with grant and pop; odd target is aligned
      restart(1, 1'b1);
      repeat (4) tick();
      check("col_pre_req",   {31'b0, imem_req}, 32'd1);
      check("col_pre_valid", {31'b0, if_valid}, 32'd1);
      check("col_pre_pc",    if_pc, 32'd4);
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      got_pc.delete();
      got_ins.delete();
      tick();
      redirect = 1'b0;
      check("col_valid", {31'b0, if_valid}, 32'd0);
      check("col_req",   {31'b0, imem_req}, 32'd0);
      tick();
      check("col_req2", {31'b0, imem_req}, 32'd1);
      check("col_addr", imem_addr, 32'h202);
      repeat (6) tick();
      check("col_first_pc",  got_pc[0], 32'h202);
      check("col_first_ins", got_ins[0], ~32'h202);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

endmodule
